// File: rtl/ifetch_prefetch_stage.sv
// Instruction-fetch prefetch stage: issues word reads from a fixed one-cycle-latency memory
// and buffers up to two {pc, inst} pairs for decode, with redirect (flush) support.
module ifetch_prefetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        id_ready,
    input  logic        flush,
    input  logic [31:0] flush_target,
    output logic [31:0] PCOUT,
    output logic [31:0] INST,
    output logic        inst_valid
);

    logic [1:0]  count_r;
    logic [31:0] pc0_r;
    logic [31:0] inst0_r;
    logic [31:0] pc1_r;
    logic [31:0] inst1_r;
    logic [31:0] fpc_r;
    logic        out_r;
    logic [31:0] out_pc_r;

    logic        pop_s;
    logic        push_s;
    logic        req_s;
    logic [2:0]  occ_s;
    logic [31:0] target_s;

    // Handshake decode: occupancy counts buffered entries plus the response still on its way.
    always_comb begin
        pop_s    = (count_r != 2'd0) && id_ready && !flush;
        push_s   = out_r && !flush;
        occ_s    = {1'b0, count_r} - {2'b00, pop_s} + {2'b00, out_r};
        req_s    = rst && !flush && (occ_s < 3'd2);
        target_s = flush_target & 32'hFFFF_FFFC;
    end

    // Output view of the FIFO head; an empty FIFO presents zeros.
    always_comb begin
        imem_req   = req_s;
        imem_addr  = fpc_r;
        inst_valid = (count_r != 2'd0);
        if (count_r != 2'd0) begin
            PCOUT = pc0_r;
            INST  = inst0_r;
        end else begin
            PCOUT = 32'h0000_0000;
            INST  = 32'h0000_0000;
        end
    end

    // Fetch PC and in-flight request tracking.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fpc_r    <= RESET_PC & 32'hFFFF_FFFC;
            out_r    <= 1'b0;
            out_pc_r <= 32'h0000_0000;
        end else if (flush) begin
            fpc_r <= target_s;
            out_r <= 1'b0;
        end else begin
            out_r <= req_s;
            if (req_s) begin
                out_pc_r <= fpc_r;
                fpc_r    <= fpc_r + 32'd4;
            end else begin
                out_pc_r <= out_pc_r;
            end
        end
    end

    // Two-entry FIFO; entry 0 is always the head, so a pop shifts entry 1 forward.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_r <= 2'd0;
            pc0_r   <= 32'h0000_0000;
            inst0_r <= 32'h0000_0000;
            pc1_r   <= 32'h0000_0000;
            inst1_r <= 32'h0000_0000;
        end else if (flush) begin
            count_r <= 2'd0;
        end else begin
            case ({pop_s, push_s})
                2'b10: begin
                    pc0_r   <= pc1_r;
                    inst0_r <= inst1_r;
                    count_r <= count_r - 2'd1;
                end
                2'b01: begin
                    if (count_r == 2'd0) begin
                        pc0_r   <= out_pc_r;
                        inst0_r <= imem_rdata;
                    end else begin
                        pc1_r   <= out_pc_r;
                        inst1_r <= imem_rdata;
                    end
                    count_r <= count_r + 2'd1;
                end
                2'b11: begin
                    if (count_r == 2'd1) begin
                        pc0_r   <= out_pc_r;
                        inst0_r <= imem_rdata;
                    end else begin
                        pc0_r   <= pc1_r;
                        inst0_r <= inst1_r;
                        pc1_r   <= out_pc_r;
                        inst1_r <= imem_rdata;
                    end
                    count_r <= count_r;
                end
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: doc/ifetch_prefetch_stage.md
IFETCH_PREFETCH_STAGE -- requirements
Module: ifetch_prefetch_stage

Interface
REQ-001 Parameter: RESET_PC, 32'h00000000, PC loaded at reset; bits [1:0] treated as 0.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low; sampled on rising clk edge.
REQ-004 imem_req  output  1  instruction-memory read request this cycle.
REQ-005 imem_addr  output  32  word-aligned read address, valid when imem_req=1.
REQ-006 imem_rdata  input  32  read data, valid exactly one cycle after the matching imem_req.
REQ-007 id_ready  input  1  decode stage accepts the head instruction this cycle.
REQ-008 flush  input  1  redirect request; discards all fetched or in-flight instructions.
REQ-009 flush_target  input  32  new fetch PC when flush=1; bits [1:0] ignored (forced 0).
REQ-010 PCOUT  output  32  PC of the head instruction.
REQ-011 INST  output  32  head instruction word.
REQ-012 inst_valid  output  1  PCOUT/INST hold a valid instruction.

Function
REQ-013 The block SHALL hold a 2-entry FIFO of {pc, inst} pairs, a 32-bit fetch PC (fpc), and a 1-bit outstanding flag marking a request issued in the previous cycle.
REQ-014 inst_valid SHALL equal (count != 0); PCOUT/INST SHALL show the FIFO head, and 0 when empty.
REQ-015 pop SHALL be inst_valid & id_ready & ~flush; pop removes the head at the clock edge.
REQ-016 imem_req SHALL be asserted iff ~flush and (count - pop + outstanding) < 2; imem_addr SHALL equal fpc.
REQ-017 On imem_req=1, fpc SHALL advance by 4 modulo 2^32 (32'hFFFFFFFC wraps to 0) and the request's PC SHALL be retained for the response.
REQ-018 When outstanding=1 and flush=0, imem_rdata with the retained PC SHALL be pushed at the clock edge; push and pop in the same cycle SHALL keep count unchanged and preserve order.
REQ-019 Latency: request in cycle n -> data pushed end of cycle n+1 -> visible (inst_valid=1) in cycle n+2.
REQ-020 Throughput: with id_ready held 1, one instruction SHALL be delivered per cycle after the initial 2-cycle latency.
REQ-021 FIFO SHALL never overflow; count SHALL stay in 0..2; with id_ready=0, fetch SHALL stop when count + outstanding = 2.
REQ-022 flush=1 SHALL, at the clock edge: empty the FIFO, clear outstanding (response arriving next cycle is dropped), load fpc = {flush_target[31:2],2'b00}; imem_req SHALL be 0 in the flush cycle.
REQ-023 flush SHALL take priority over pop, push and request issue in the same cycle; id_ready is ignored during flush.
REQ-024 The first request after flush SHALL be issued in the following cycle at the new fpc; first post-flush instruction visible two cycles after that.
REQ-025 Back-to-back flush cycles SHALL each reload fpc; only the last target takes effect.

Reset
REQ-026 While rst=0 at a clock edge: fpc=RESET_PC, FIFO empty, outstanding=0; hence imem_req=0, inst_valid=0, PCOUT=0, INST=0 in the following cycle.
REQ-027 Reset SHALL override flush and all in-flight activity; a response arriving in the cycle after reset release SHALL be discarded.
REQ-028 First request SHALL be issued in the first cycle with rst=1, at address RESET_PC.

Verification
REQ-029 Reset release, RESET_PC=0, memory returns addr^32'hA5A5A5A5, id_ready=1 -> imem_req at cycle 0 addr 0; inst_valid at cycle 2 with PCOUT=0, INST=32'hA5A5A5A5; then PCOUT 4, 8, 12 on consecutive cycles.
REQ-030 Streaming, then id_ready=0 for 5 cycles -> count reaches 2, imem_req deasserts, PCOUT/INST frozen; on id_ready=1 the sequence resumes with no skipped or duplicated PC.
REQ-031 flush=1, flush_target=32'h00000103 while outstanding=1 -> stale response dropped, inst_valid=0 next cycle, next request at 32'h00000100, first delivered PCOUT=32'h00000100.
REQ-032 flush with flush_target=32'hFFFFFFF8, id_ready=1 -> delivered PCs FFFFFFF8, FFFFFFFC, 00000000, 00000004.
REQ-033 rst=0 asserted mid-stream with FIFO full and flush=1 in the same cycle -> next cycle all outputs 0; fetching restarts at RESET_PC after release.
REQ-034 Random id_ready/flush for 10k cycles against a reference queue model -> delivered {PCOUT, INST} order matches model, count never exceeds 2.
